uart_frame_decoder: RTL
=======================

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte width.
REQ-002 SHALL have parameter SWITCH_COUNT, default 16, width of decoded switch word.
REQ-003 SHALL have parameter BUTTON_COUNT, default 5, width of decoded button word.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 500_000, maximum idle clocks between bytes inside a frame.
REQ-005 SHALL have port clk  input  1  single clock for all state.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ena  input  1  clock enable; low freezes all state and ignores rx_valid.
REQ-008 SHALL have port rx_data  input  DATA_WIDTH  received byte from UART receiver.
REQ-009 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-010 SHALL have port switch_data  output  SWITCH_COUNT  last accepted switch word.
REQ-011 SHALL have port button_data  output  BUTTON_COUNT  last accepted button word.
REQ-012 SHALL have port ack_data  output  DATA_WIDTH  response byte toward TX FIFO.
REQ-013 SHALL have port ack_valid  output  1  ack_data valid, held until ack_ready.
REQ-014 SHALL have port ack_ready  input  1  TX FIFO accepts ack_data when high with ack_valid.
REQ-015 SHALL have port frame_err_count  output  8  saturating count of rejected frames.

Function
REQ-016 SHALL accept frames 'S'(0x53)+4 hex digits+LF(0x0A) and 'B'(0x42)+2 hex digits+LF; digits MSB first, 0-9/A-F/a-f.
REQ-017 SHALL implement states IDLE, S_DIGITS, B_DIGITS, WAIT_LF, DISCARD with a 3-bit digit counter.
REQ-018 IDLE: 'S' -> S_DIGITS, 'B' -> B_DIGITS, LF/CR ignored, any other byte -> DISCARD with error.
REQ-019 S_DIGITS/B_DIGITS: valid hex shifts 4 bits into accumulator; after 4 (S) or 2 (B) digits -> WAIT_LF.
REQ-020 CR (0x0D) SHALL be ignored in S_DIGITS, B_DIGITS and WAIT_LF.
REQ-021 WAIT_LF: LF commits the frame and -> IDLE; any other byte -> DISCARD with error.
REQ-022 Non-hex byte in a digit state, or LF before the digit count is reached, SHALL be an error.
REQ-023 DISCARD SHALL drop bytes until LF, then -> IDLE; the error is counted once, on entry to DISCARD.
REQ-024 An LF causing the error SHALL return directly to IDLE.
REQ-025 Commit SHALL update switch_data (S) or button_data (B, low BUTTON_COUNT bits, upper bits ignored) on the clock after LF is sampled.
REQ-026 Non-committed frames SHALL never alter switch_data or button_data.
REQ-027 Inter-byte timer SHALL run in all non-IDLE states, restart on each rx_valid, and on reaching TIMEOUT_CYCLES abort -> IDLE with error.
REQ-028 Timeout expiry and rx_valid in the same cycle: the byte SHALL win and the timer restarts.
REQ-029 frame_err_count SHALL increment by 1 per error and saturate at 255.
REQ-030 Commit SHALL queue ack 'K'(0x4B); an error SHALL queue ack 'E'(0x45) at the error event (DISCARD entry or timeout).
REQ-031 Ack SHALL be a 1-entry register: ack_valid rises the cycle after queueing, and ack_data stays stable until the ack_valid&&ack_ready handshake.
REQ-032 A new ack SHALL be dropped while one is pending; a handshake and a new ack in the same cycle SHALL load the new ack.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, accumulator/counters/timer 0, switch_data 0, button_data 0, ack_valid 0, ack_data 0, frame_err_count 0.
REQ-034 Reset mid-frame SHALL discard the partial frame with no commit and no ack.

Configuration
REQ-035 Macro UART_FRAME_ACK_EN SHALL compile in the ack path (REQ-030..032).
REQ-036 Without UART_FRAME_ACK_EN, ack_valid and ack_data SHALL be constant 0 and ack_ready unused; decoding and counting are unchanged.

Structure
REQ-037 Package uart_frame_pkg SHALL hold the state enum, character constants (S, B, LF, CR, K, E) and the 8-bit error count type.
REQ-038 Sub-module hex_ascii_decode SHALL map a byte to {valid, 4-bit nibble} combinationally.

Verification
REQ-039 "S1A2F\n" -> switch_data=0x1A2F one cycle after LF; ack 'K'; frame_err_count=0.
REQ-040 "B1f\r\n" -> button_data=0x1F; switch_data unchanged; ack 'K'.
REQ-041 "S12G4\n" -> no update; frame_err_count+1; single ack 'E'; following "S0001\n" -> 0x0001.
REQ-042 "S12" then TIMEOUT_CYCLES idle -> IDLE; error +1; ack 'E'; with rx_valid on the expiry cycle -> no timeout.
REQ-043 ack_ready held low across two good frames -> only first 'K' is presented; it stays stable until ack_ready is raised.
REQ-044 260 bad frames -> frame_err_count=255; rst_n pulse mid-frame "S1" -> all outputs 0, no ack.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Purpose: shared state encodings, character codes and count type for the UART frame decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_frame_pkg;

    // Decoder states, kept as plain constants so older tools and netlists see a stable encoding.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_S_DIGITS = 3'd1;
    localparam state_t ST_B_DIGITS = 3'd2;
    localparam state_t ST_WAIT_LF  = 3'd3;
    localparam state_t ST_DISCARD  = 3'd4;

    // ASCII codes for the frame protocol.
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_B  = 8'h42;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;

    // Saturating rejected-frame counter.
    typedef logic [7:0] err_count_t;
    localparam err_count_t ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/hex_ascii_decode.sv
// Purpose: map one received character to {hex_valid, nibble}; accepts 0-9, A-F, a-f.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   char_in   - received character
//   hex_valid - char_in is a hex digit
//   nibble    - digit value (0 when hex_valid is low)
module hex_ascii_decode #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] char_in,
    output logic                  hex_valid,
    output logic [3:0]            nibble
);

    logic [31:0] code;

    always_comb begin
        // Widen first so the range tests are correct for any byte width.
        code      = 32'(char_in);
        hex_valid = 1'b0;
        nibble    = 4'h0;
        if (code >= 32'h30 && code <= 32'h39) begin
            hex_valid = 1'b1;
            nibble    = 4'(code - 32'h30);
        end else if (code >= 32'h41 && code <= 32'h46) begin
            hex_valid = 1'b1;
            nibble    = 4'(code - 32'h37);
        end else if (code >= 32'h61 && code <= 32'h66) begin
            hex_valid = 1'b1;
            nibble    = 4'(code - 32'h57);
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Purpose: decode "Sxxxx\n" switch and "Bxx\n" button frames from a UART byte stream, count rejects.
// Latency: switch/button outputs and ack_valid update on the edge that samples the terminating LF.
// Backpressure: none on rx (one byte per strobe); ack is a 1-entry register, new acks dropped while pending.
//
// Optional feature: define UART_FRAME_ACK_EN to build the 'K'/'E' response path;
// without it ack_valid/ack_data are tied to 0 and ack_ready is ignored.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   ena               - clock enable; low freezes every register and ignores rx_valid
//   rx_data, rx_valid - received byte and its one-cycle strobe
//   switch_data       - last committed switch word
//   button_data       - last committed button word
//   ack_data/valid    - response byte toward the TX FIFO, held until ack_ready
//   ack_ready         - TX FIFO accepts ack_data
//   frame_err_count   - saturating count of rejected frames
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int SWITCH_COUNT   = 16,
    parameter int BUTTON_COUNT   = 5,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [SWITCH_COUNT-1:0] switch_data,
    output logic [BUTTON_COUNT-1:0] button_data,
    output logic [DATA_WIDTH-1:0]   ack_data,
    output logic                    ack_valid,
    input  logic                    ack_ready,
    output logic [7:0]              frame_err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [2:0]    digit_cnt, cnt_nxt;
    logic [15:0]   acc, acc_nxt;
    logic [TW-1:0] timer, timer_nxt;
    err_count_t    err_count;
    logic          commit_s, commit_b, err_evt;

    logic          hex_valid;
    logic [3:0]    nibble;
    logic          is_s, is_b, is_lf, is_cr;

    hex_ascii_decode #(.DATA_WIDTH(DATA_WIDTH)) u_hex (
        .char_in   (rx_data),
        .hex_valid (hex_valid),
        .nibble    (nibble)
    );

    assign is_s  = (rx_data == DATA_WIDTH'(CH_S));
    assign is_b  = (rx_data == DATA_WIDTH'(CH_B));
    assign is_lf = (rx_data == DATA_WIDTH'(CH_LF));
    assign is_cr = (rx_data == DATA_WIDTH'(CH_CR));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = digit_cnt;
        acc_nxt   = acc;
        timer_nxt = timer;
        commit_s  = 1'b0;
        commit_b  = 1'b0;
        err_evt   = 1'b0;
        if (rx_valid) begin
            // Any byte restarts the inter-byte timer, including on the expiry cycle.
            timer_nxt = '0;
            case (state)
                ST_IDLE: begin
                    if (is_s) begin
                        state_nxt = ST_S_DIGITS;
                        cnt_nxt   = 3'd0;
                        acc_nxt   = '0;
                    end else if (is_b) begin
                        state_nxt = ST_B_DIGITS;
                        cnt_nxt   = 3'd0;
                        acc_nxt   = '0;
                    end else if (!is_lf && !is_cr) begin
                        state_nxt = ST_DISCARD;
                        err_evt   = 1'b1;
                    end
                end
                ST_S_DIGITS, ST_B_DIGITS: begin
                    if (hex_valid) begin
                        acc_nxt = {acc[11:0], nibble};
                        cnt_nxt = digit_cnt + 3'd1;
                        if (cnt_nxt == ((state == ST_S_DIGITS) ? 3'd4 : 3'd2))
                            state_nxt = ST_WAIT_LF;
                    end else if (!is_cr) begin
                        // An early LF already ends the line, so nothing is left to discard.
                        err_evt   = 1'b1;
                        state_nxt = is_lf ? ST_IDLE : ST_DISCARD;
                    end
                end
                ST_WAIT_LF: begin
                    if (is_lf) begin
                        // Digit count tells which frame type is being closed.
                        commit_s  = (digit_cnt == 3'd4);
                        commit_b  = (digit_cnt != 3'd4);
                        state_nxt = ST_IDLE;
                    end else if (!is_cr) begin
                        err_evt   = 1'b1;
                        state_nxt = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (is_lf)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (state != ST_IDLE) begin
            if (timer == TIMEOUT_LAST) begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
                err_evt   = 1'b1;
            end else begin
                timer_nxt = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            digit_cnt   <= '0;
            acc         <= '0;
            timer       <= '0;
            err_count   <= '0;
            switch_data <= '0;
            button_data <= '0;
        end else if (ena) begin
            state     <= state_nxt;
            digit_cnt <= cnt_nxt;
            acc       <= acc_nxt;
            timer     <= timer_nxt;
            if (commit_s)
                switch_data <= SWITCH_COUNT'(acc);
            if (commit_b)
                button_data <= BUTTON_COUNT'(acc[7:0]);
            if (err_evt && err_count != ERR_COUNT_MAX)
                err_count <= err_count + 8'd1;
        end
    end

    assign frame_err_count = err_count;

`ifdef UART_FRAME_ACK_EN
    logic                  ack_queue;
    logic [DATA_WIDTH-1:0] ack_char;

    assign ack_queue = commit_s | commit_b | err_evt;
    assign ack_char  = err_evt ? DATA_WIDTH'(CH_E) : DATA_WIDTH'(CH_K);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_valid <= 1'b0;
            ack_data  <= '0;
        end else if (ena) begin
            // Slot is free if empty or being drained this cycle; otherwise the new ack is lost.
            if (ack_queue && (!ack_valid || ack_ready)) begin
                ack_valid <= 1'b1;
                ack_data  <= ack_char;
            end else if (ack_valid && ack_ready) begin
                ack_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_ack_ready;
    assign unused_ack_ready = ack_ready;
    assign ack_valid        = 1'b0;
    assign ack_data         = '0;
`endif

endmodule
